keypad_entry_ctrl: RTL and testbench

- Sequences the 4x4 matrix keypad scanner into a decimal number-entry device for the CPU IO space.
- Takes the scanner's decoded key code and key-held level, debounces press and release, and applies one action per physical press.
- Holds the typed digits, converts them to a 16-bit two's-complement value on Enter, and presents the value to the CPU through a ready/read handshake.
- The live digit buffer also drives the seven-segment display.

---
 rtl/keypad_entry_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// Keypad number-entry controller: debounces the scanner's key level, applies one
// action per press, and converts the BCD digit buffer into a saturated 16-bit value.
module keypad_entry_ctrl #(
  parameter int MAX_DIGITS      = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              key_val,
  input  logic                    key_down,
  input  logic                    cpu_rd,
  output logic [15:0]             cpu_data,
  output logic                    data_ready,
  output logic                    overrun,
  output logic                    overflow,
  output logic [4*MAX_DIGITS-1:0] disp_digits,
  output logic [2:0]              digit_cnt,
  output logic                    neg
);

  localparam int DW = 4 * MAX_DIGITS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [2:0]    CNT_MAX = 3'(MAX_DIGITS);

  typedef enum logic [2:0] {
    WAIT_PRESS, DEBOUNCE, ACTION, CONVERT, WAIT_RELEASE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [16:0]     acc_reg, acc_next;
  logic [2:0]      idx_reg, idx_next;
  logic [DW-1:0]   digits_reg, digits_next;
  logic [2:0]      dcnt_reg, dcnt_next;
  logic            neg_reg, neg_next;
  logic [15:0]     data_reg, data_next;
  logic            ready_reg, ready_next;
  logic            ovr_reg, ovr_next;
  logic            ovf_reg, ovf_next;
  logic            publish;

  logic [DW-1:0]   shift_up, shift_down;
  logic [3:0]      digit_arr [MAX_DIGITS];

  // Per-digit wiring of the buffer views used by digit entry, backspace and conversion.
  generate
    for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = digits_reg[4*gi +: 4];
      if (gi == 0) begin : g_lo
        assign shift_up[3:0] = key_val;
      end else begin : g_up
        assign shift_up[4*gi +: 4] = digits_reg[4*(gi-1) +: 4];
      end
      if (gi == MAX_DIGITS - 1) begin : g_top
        assign shift_down[4*gi +: 4] = 4'd0;
      end else begin : g_dn
        assign shift_down[4*gi +: 4] = digits_reg[4*(gi+1) +: 4];
      end
    end
  endgenerate

  logic [16:0] acc_step;
  logic        sat;
  logic [14:0] mag;
  logic [15:0] signed_val;

  assign acc_step   = acc_reg * 17'd10 + {13'd0, digit_arr[idx_reg]};
  assign sat        = acc_step > 17'd32767;
  assign mag        = sat ? 15'h7FFF : acc_step[14:0];
  assign signed_val = neg_reg ? (16'd0 - {1'b0, mag}) : {1'b0, mag};

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    idx_next    = idx_reg;
    digits_next = digits_reg;
    dcnt_next   = dcnt_reg;
    neg_next    = neg_reg;
    data_next   = data_reg;
    ovf_next    = ovf_reg;
    publish     = 1'b0;
    case (state_reg)
      WAIT_PRESS: begin
        if (key_down) begin
          state_next = DEBOUNCE;
          cnt_next   = CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (!key_down) begin
          state_next = WAIT_PRESS;
          cnt_next   = '0;
        end else if (cnt_reg == DB_LAST) begin
          state_next = ACTION;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ACTION: begin
        state_next = WAIT_RELEASE;
        cnt_next   = '0;
        case (key_val)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
            if (dcnt_reg < CNT_MAX) begin
              digits_next = shift_up;
              dcnt_next   = dcnt_reg + 3'd1;
            end
          end
          4'hA: begin
            state_next = CONVERT;
            acc_next   = '0;
            // Walk from the oldest (most significant) digit down to digit 0.
            idx_next   = (dcnt_reg == 3'd0) ? 3'd0 : dcnt_reg - 3'd1;
          end
          4'hB: begin
            if (dcnt_reg != 3'd0) begin
              digits_next = shift_down;
              dcnt_next   = dcnt_reg - 3'd1;
            end
          end
          4'hC: begin
            digits_next = '0;
            dcnt_next   = 3'd0;
            neg_next    = 1'b0;
          end
          4'hD: neg_next = ~neg_reg;
          default: ;
        endcase
      end
      CONVERT: begin
        acc_next = acc_step;
        if (idx_reg == 3'd0) begin
          publish     = 1'b1;
          data_next   = signed_val;
          ovf_next    = sat;
          digits_next = '0;
          dcnt_next   = 3'd0;
          neg_next    = 1'b0;
          state_next  = WAIT_RELEASE;
          cnt_next    = '0;
        end else begin
          idx_next = idx_reg - 3'd1;
        end
      end
      WAIT_RELEASE: begin
        if (key_down) begin
          cnt_next = '0;
        end else if (cnt_reg == DB_LAST - CNT_ONE) begin
          state_next = WAIT_PRESS;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = WAIT_PRESS;
        cnt_next   = '0;
      end
    endcase
    // A publish beats a coinciding read, and that read still clears overrun.
    ready_next = publish | (ready_reg & ~cpu_rd);
    ovr_next   = ~cpu_rd & (ovr_reg | (publish & ready_reg));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= WAIT_PRESS;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      idx_reg    <= 3'd0;
      digits_reg <= '0;
      dcnt_reg   <= 3'd0;
      neg_reg    <= 1'b0;
      data_reg   <= 16'd0;
      ready_reg  <= 1'b0;
      ovr_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      idx_reg    <= idx_next;
      digits_reg <= digits_next;
      dcnt_reg   <= dcnt_next;
      neg_reg    <= neg_next;
      data_reg   <= data_next;
      ready_reg  <= ready_next;
      ovr_reg    <= ovr_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign cpu_data    = data_reg;
  assign data_ready  = ready_reg;
  assign overrun     = ovr_reg;
  assign overflow    = ovf_reg;
  assign disp_digits = digits_reg;
  assign digit_cnt   = dcnt_reg;
  assign neg         = neg_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: key-press vector table, published values checked
// through a scoreboard queue, plus hand-written debounce/handshake/reset sequences.
module tb_keypad_entry_ctrl;

  localparam int MD = 5;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    key_val = 4'h0;
  logic          key_down = 1'b0;
  logic          cpu_rd = 1'b0;
  logic [15:0]   cpu_data;
  logic          data_ready, overrun, overflow, neg;
  logic [4*MD-1:0] disp_digits;
  logic [2:0]    digit_cnt;

  keypad_entry_ctrl #(.MAX_DIGITS(MD), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .key_val(key_val), .key_down(key_down), .cpu_rd(cpu_rd),
    .cpu_data(cpu_data), .data_ready(data_ready), .overrun(overrun), .overflow(overflow),
    .disp_digits(disp_digits), .digit_cnt(digit_cnt), .neg(neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  key;
    logic [2:0]  cnt;
    logic [19:0] disp;
    logic        neg;
    logic [15:0] data;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
  } pub_t;

  vec_t vecs[$];
  pub_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic mon_prev = 1'b0;
  pub_t mon_item;
  int   first_hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_val  = k;
    key_down = 1'b1;
    repeat (8) @(negedge clk);
    key_down = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  task automatic add(input logic [3:0] k, input logic [2:0] c, input logic [19:0] d,
                     input logic n, input logic [15:0] v, input logic o);
    vec_t t;
    t.key = k; t.cnt = c; t.disp = d; t.neg = n; t.data = v; t.ovf = o;
    vecs.push_back(t);
  endtask

  // Scoreboard: each rising data_ready must match the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (data_ready && !mon_prev) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_publish: got cpu_data=%h, required no publish", cpu_data);
        end else begin
          mon_item = sb.pop_front();
          $display("[TB] publish cpu_data=%h overflow=%0b", cpu_data, overflow);
          check("pub_data", 32'(cpu_data), 32'(mon_item.data));
          check("pub_overflow", 32'(overflow), 32'(mon_item.ovf));
        end
      end
      mon_prev = data_ready;
    end
  end

  initial begin
    // key, digit_cnt, disp_digits, neg after the press; data/overflow for Enter
    add(4'h1, 3'd1, 20'h00001, 1'b0, 16'h0000, 1'b0);
    add(4'h2, 3'd2, 20'h00012, 1'b0, 16'h0000, 1'b0);
    add(4'h3, 3'd3, 20'h00123, 1'b0, 16'h0000, 1'b0);
    add(4'hA, 3'd0, 20'h00000, 1'b0, 16'h007B, 1'b0);
    add(4'hD, 3'd0, 20'h00000, 1'b1, 16'h0000, 1'b0);
    add(4'h4, 3'd1, 20'h00004, 1'b1, 16'h0000, 1'b0);
    add(4'h0, 3'd2, 20'h00040, 1'b1, 16'h0000, 1'b0);
    add(4'h0, 3'd3, 20'h00400, 1'b1, 16'h0000, 1'b0);
    add(4'h0, 3'd4, 20'h04000, 1'b1, 16'h0000, 1'b0);
    add(4'h0, 3'd5, 20'h40000, 1'b1, 16'h0000, 1'b0);
    add(4'hA, 3'd0, 20'h00000, 1'b0, 16'h8001, 1'b1);
    add(4'h9, 3'd1, 20'h00009, 1'b0, 16'h0000, 1'b0);
    add(4'h9, 3'd2, 20'h00099, 1'b0, 16'h0000, 1'b0);
    add(4'h9, 3'd3, 20'h00999, 1'b0, 16'h0000, 1'b0);
    add(4'h9, 3'd4, 20'h09999, 1'b0, 16'h0000, 1'b0);
    add(4'h9, 3'd5, 20'h99999, 1'b0, 16'h0000, 1'b0);
    add(4'h9, 3'd5, 20'h99999, 1'b0, 16'h0000, 1'b0);
    add(4'hA, 3'd0, 20'h00000, 1'b0, 16'h7FFF, 1'b1);
    add(4'h5, 3'd1, 20'h00005, 1'b0, 16'h0000, 1'b0);
    add(4'h6, 3'd2, 20'h00056, 1'b0, 16'h0000, 1'b0);
    add(4'hB, 3'd1, 20'h00005, 1'b0, 16'h0000, 1'b0);
    add(4'h8, 3'd2, 20'h00058, 1'b0, 16'h0000, 1'b0);
    add(4'hC, 3'd0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    add(4'h3, 3'd1, 20'h00003, 1'b0, 16'h0000, 1'b0);
    add(4'hA, 3'd0, 20'h00000, 1'b0, 16'h0003, 1'b0);
    add(4'hA, 3'd0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    add(4'hD, 3'd0, 20'h00000, 1'b1, 16'h0000, 1'b0);
    add(4'hA, 3'd0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    add(4'hE, 3'd0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    add(4'hB, 3'd0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    add(4'hD, 3'd0, 20'h00000, 1'b1, 16'h0000, 1'b0);
    add(4'h1, 3'd1, 20'h00001, 1'b1, 16'h0000, 1'b0);
    add(4'hC, 3'd0, 20'h00000, 1'b0, 16'h0000, 1'b0);
    add(4'hD, 3'd0, 20'h00000, 1'b1, 16'h0000, 1'b0);
    add(4'h2, 3'd1, 20'h00002, 1'b1, 16'h0000, 1'b0);
    add(4'h5, 3'd2, 20'h00025, 1'b1, 16'h0000, 1'b0);
    add(4'h6, 3'd3, 20'h00256, 1'b1, 16'h0000, 1'b0);
    add(4'hA, 3'd0, 20'h00000, 1'b0, 16'hFF00, 1'b0);
    add(4'h3, 3'd1, 20'h00003, 1'b0, 16'h0000, 1'b0);
    add(4'h2, 3'd2, 20'h00032, 1'b0, 16'h0000, 1'b0);
    add(4'h7, 3'd3, 20'h00327, 1'b0, 16'h0000, 1'b0);
    add(4'h6, 3'd4, 20'h03276, 1'b0, 16'h0000, 1'b0);
    add(4'h8, 3'd5, 20'h32768, 1'b0, 16'h0000, 1'b0);
    add(4'hA, 3'd0, 20'h00000, 1'b0, 16'h7FFF, 1'b1);
    add(4'h3, 3'd1, 20'h00003, 1'b0, 16'h0000, 1'b0);
    add(4'h2, 3'd2, 20'h00032, 1'b0, 16'h0000, 1'b0);
    add(4'h7, 3'd3, 20'h00327, 1'b0, 16'h0000, 1'b0);
    add(4'h6, 3'd4, 20'h03276, 1'b0, 16'h0000, 1'b0);
    add(4'h7, 3'd5, 20'h32767, 1'b0, 16'h0000, 1'b0);
    add(4'hA, 3'd0, 20'h00000, 1'b0, 16'h7FFF, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cpu_data", 32'(cpu_data), 32'h0);
    check("rst_data_ready", 32'(data_ready), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_disp", 32'(disp_digits), 32'h0);
    check("rst_digit_cnt", 32'(digit_cnt), 32'h0);
    check("rst_neg", 32'(neg), 32'h0);
    rst = 1'b0;

    // Debounce: 3-cycle glitch is rejected, 20-cycle hold yields one digit.
    @(negedge clk);
    key_val  = 4'h7;
    key_down = 1'b1;
    repeat (3) @(negedge clk);
    key_down = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_digit_cnt", 32'(digit_cnt), 32'h0);
    key_down  = 1'b1;
    first_hit = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (first_hit < 0 && digit_cnt != 3'd0) first_hit = i;
    end
    // ACTION is the state after the 5th edge of the hold; its update shows after the 6th.
    check("action_latency", 32'(first_hit), 32'd6);
    key_down = 1'b0;
    repeat (12) @(negedge clk);
    $display("[TB] hold key 7: digit_cnt=%0d disp=%h", digit_cnt, disp_digits);
    check("hold_digit_cnt", 32'(digit_cnt), 32'd1);
    check("hold_digit0", 32'(disp_digits[3:0]), 32'h7);
    press(4'hC);
    check("clear_after_hold", 32'(digit_cnt), 32'h0);

    // Table-driven key sequence
    foreach (vecs[i]) begin
      if (vecs[i].key == 4'hA) sb.push_back('{vecs[i].data, vecs[i].ovf});
      press(vecs[i].key);
      $display("[TB] key %h: digit_cnt=%0d disp=%h neg=%0b", vecs[i].key, digit_cnt, disp_digits, neg);
      check("vec_digit_cnt", 32'(digit_cnt), 32'(vecs[i].cnt));
      check("vec_disp", 32'(disp_digits), 32'(vecs[i].disp));
      check("vec_neg", 32'(neg), 32'(vecs[i].neg));
      if (vecs[i].key == 4'hA) begin
        check("vec_sb_drained", 32'(sb.size()), 32'd0);
        read_pulse();
        check("vec_rd_ready", 32'(data_ready), 32'h0);
        check("vec_rd_overrun", 32'(overrun), 32'h0);
      end
    end

    // Two publishes without a read set overrun.
    press(4'h1);
    sb.push_back('{16'h0001, 1'b0});
    press(4'hA);
    press(4'h2);
    press(4'hA);
    $display("[TB] double publish: cpu_data=%h overrun=%0b", cpu_data, overrun);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_ready", 32'(data_ready), 32'h1);
    check("ovr_data", 32'(cpu_data), 32'h0002);

    // Reset during the 2nd CONVERT cycle of a 3-digit entry.
    press(4'h1);
    press(4'h2);
    press(4'h3);
    @(negedge clk);
    key_val  = 4'hA;
    key_down = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    key_down = 1'b0;
    $display("[TB] mid-convert reset: cpu_data=%h data_ready=%0b", cpu_data, data_ready);
    check("mrst_cpu_data", 32'(cpu_data), 32'h0);
    check("mrst_data_ready", 32'(data_ready), 32'h0);
    check("mrst_overrun", 32'(overrun), 32'h0);
    check("mrst_overflow", 32'(overflow), 32'h0);
    check("mrst_disp", 32'(disp_digits), 32'h0);
    check("mrst_digit_cnt", 32'(digit_cnt), 32'h0);
    check("mrst_neg", 32'(neg), 32'h0);
    repeat (10) @(negedge clk);
    check("mrst_no_late_pub", 32'(data_ready), 32'h0);
    press(4'h4);
    check("mrst_next_cnt", 32'(digit_cnt), 32'd1);
    check("mrst_next_disp", 32'(disp_digits), 32'h4);

    // cpu_rd coinciding with a publish while data_ready is already set.
    sb.push_back('{16'h0004, 1'b0});
    press(4'hA);
    press(4'h9);
    @(negedge clk);
    key_val  = 4'hA;
    key_down = 1'b1;
    repeat (6) @(negedge clk);
    cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd   = 1'b0;
    $display("[TB] read at publish: data_ready=%0b overrun=%0b cpu_data=%h", data_ready, overrun, cpu_data);
    check("coin_ready", 32'(data_ready), 32'h1);
    check("coin_overrun", 32'(overrun), 32'h0);
    check("coin_data", 32'(cpu_data), 32'h0009);
    key_down = 1'b0;
    repeat (12) @(negedge clk);

    // cpu_rd alone, then again with nothing pending.
    read_pulse();
    check("rd_ready", 32'(data_ready), 32'h0);
    check("rd_overrun", 32'(overrun), 32'h0);
    check("rd_hold_data", 32'(cpu_data), 32'h0009);
    read_pulse();
    check("rd_idle_ready", 32'(data_ready), 32'h0);
    check("rd_idle_data", 32'(cpu_data), 32'h0009);

    check("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
